// File: rtl/tokenflow_seq_src.sv
// Adder-only sequence generator feeding a DEPTH-entry FIFO, drained over a 4-phase req/ack channel.
// Optional handshake counter on port xfer_count when TOKENFLOW_STATS_EN is defined.
module tokenflow_seq_src #(
  parameter int W           = 16,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [1:0]   mode,
  output logic         out_req,
  output logic [W-1:0] out_data,
  input  logic         out_ack,
  output logic         wrapped
`ifdef TOKENFLOW_STATS_EN
  ,
  output logic [31:0]  xfer_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // state | meaning
  // IDLE  | no request outstanding; load head when FIFO non-empty
  // REQ   | out_req high, waiting for synchronised ack
  // RTZ   | head popped, out_req low, waiting for ack to return to zero
  typedef enum logic [1:0] {IDLE, REQ, RTZ} state_t;

  state_t state, state_nxt;

  logic [1:0]             mode_q;
  logic [W-1:0]           acc, step;
  logic [W:0]             sum;
  logic [W-1:0]           mem [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic                   full, empty, push, pop, load;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = en & ~full;
  assign sum   = {1'b0, acc} + {1'b0, step};
  assign ack_s = ack_sync[SYNC_STAGES-1];

  // mode is only honoured while reset is held, so the step seed comes from the live input.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= mode;
      acc     <= '0;
      step    <= (mode == 2'b00) ? W'(2) : W'(1);
      wrapped <= 1'b0;
    end else begin
      wrapped <= push & sum[W];
      if (push) begin
        acc <= sum[W-1:0];
        case (mode_q)
          2'b00:   step <= step + W'(2);
          2'b10:   step <= step + W'(2);
          2'b11:   step <= step + W'(1);
          default: step <= step;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ack_sync <= '0;
    else       ack_sync <= {ack_sync[SYNC_STAGES-2:0], out_ack};
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        load      = 1'b1;
        state_nxt = REQ;
      end
      REQ: if (ack_s) begin
        pop       = 1'b1;
        state_nxt = RTZ;
      end
      RTZ: if (!ack_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // out_req is its own flop so the asynchronous sink never sees a decode glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      out_req  <= 1'b0;
      out_data <= '0;
    end else begin
      state   <= state_nxt;
      out_req <= (state_nxt == REQ);
      if (load) out_data <= mem[rd_ptr];
    end
  end

`ifdef TOKENFLOW_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)                      xfer_count <= '0;
    else if (state == REQ && ack_s) xfer_count <= xfer_count + 32'd1;
  end
`endif

endmodule
